// File: rtl/axis_tile_buffer.sv
// rtl/axis_tile_buffer.sv - ping-pong tile buffer between the DMA stream and the compute array
// Two banks alternate: one fills from s_axis while the other replays a complete tile to the array.
module axis_tile_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int TILE_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  arr_valid,
  input  logic                  arr_ready,
  output logic [DATA_WIDTH-1:0] arr_data,
  output logic                  arr_first,
  output logic                  arr_last,
  output logic                  busy,
  output logic [15:0]           tiles_done
);

  localparam int CW = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TILE_DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t     bank_q [2];
  bank_state_t     bank_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]     tiles_q, tiles_d;
  logic            wr_fire, rd_fire;

  logic [DATA_WIDTH-1:0] mem [2][TILE_DEPTH];

  assign s_axis_tready = (bank_q[wr_bank_q] != FULL) && !flush;
  assign arr_valid     = (bank_q[rd_bank_q] == FULL);
  assign arr_data      = mem[rd_bank_q][rd_cnt_q];
  assign arr_first     = (rd_cnt_q == '0);
  assign arr_last      = (rd_cnt_q == LAST_IDX);
  assign busy          = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY);
  assign tiles_done    = tiles_q;

  assign wr_fire = s_axis_tvalid && s_axis_tready;
  assign rd_fire = arr_valid && arr_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      tiles_q   <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      tiles_q   <= tiles_d;
    end
  end

  // Storage carries no reset; contents are only observed once a bank is FULL.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_cnt_q] <= s_axis_tdata;
    end
  end

  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    tiles_d   = tiles_q;

    if (flush) begin
      bank_d[0] = EMPTY;
      bank_d[1] = EMPTY;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
    end else begin
      // Writer and reader never share a bank: the writer's bank is never FULL, the reader's always is.
      if (wr_fire) begin
        if (wr_cnt_q == LAST_IDX) begin
          bank_d[wr_bank_q] = FULL;
          wr_bank_d         = ~wr_bank_q;
          wr_cnt_d          = '0;
        end else begin
          bank_d[wr_bank_q] = FILLING;
          wr_cnt_d          = wr_cnt_q + CW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_cnt_q == LAST_IDX) begin
          bank_d[rd_bank_q] = EMPTY;
          rd_bank_d         = ~rd_bank_q;
          rd_cnt_d          = '0;
          tiles_d           = tiles_q + 16'd1;
        end else begin
          rd_cnt_d          = rd_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
